// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared RV32 opcodes, branch funct3 codes, NOP and immediate extractors
package riscv_pkg;

  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_RSV2 = 3'b010,
    F3_RSV3 = 3'b011,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } br_f3_e;

  // B-type immediate, 13 bits with bit0 = 0, sign-extended
  function automatic logic [31:0] imm_b(input logic [31:0] inst);
    return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
  endfunction

  // J-type immediate, 21 bits with bit0 = 0, sign-extended
  function automatic logic [31:0] imm_j(input logic [31:0] inst);
    return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
  endfunction

  // I-type immediate, 12 bits, sign-extended
  function automatic logic [31:0] imm_i(input logic [31:0] inst);
    return {{20{inst[31]}}, inst[31:20]};
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// rtl/branch_cmp.sv - combinational branch condition evaluator for the BRANCH funct3 codes
module branch_cmp
  import riscv_pkg::*;
(
  input  logic [31:0] rs1_i,
  input  logic [31:0] rs2_i,
  input  logic [2:0]  funct3_i,
  output logic        taken_o,
  output logic        illegal_o
);

  // Evaluate the condition selected by funct3; reserved codes never take
  always_comb begin
    taken_o   = 1'b0;
    illegal_o = 1'b0;
    case (funct3_i)
      F3_BEQ:  taken_o = (rs1_i == rs2_i);
      F3_BNE:  taken_o = (rs1_i != rs2_i);
      F3_BLT:  taken_o = ($signed(rs1_i) <  $signed(rs2_i));
      F3_BGE:  taken_o = ($signed(rs1_i) >= $signed(rs2_i));
      F3_BLTU: taken_o = (rs1_i <  rs2_i);
      F3_BGEU: taken_o = (rs1_i >= rs2_i);
      default: illegal_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/branch_resolve.sv
// rtl/branch_resolve.sv - X-stage JAL/JALR/BRANCH resolver and fetch redirect source; option BRANCH_MISALIGN_TRAP_EN
module branch_resolve
  import riscv_pkg::*;
#(
  parameter int          CNT_W    = 16,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             inst_v_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      inst_i,
  input  logic [31:0]      rs1_x,
  input  logic [31:0]      rs2_x,
  output logic             inst_v_x,
  output logic             pc_v_x,
  output logic [31:0]      pc_x,
  output logic             link_v_x,
  output logic [31:0]      link_x,
  output logic             illegal_x,
`ifdef BRANCH_MISALIGN_TRAP_EN
  output logic             trap_v_x,
  output logic [31:0]      trap_tval_x,
`endif
  output logic [CNT_W-1:0] taken_cnt
);

  logic             inst_v_q, inst_v_d;
  logic [31:0]      pc_q, pc_d;
  logic [31:0]      inst_q, inst_d;
  logic [CNT_W-1:0] taken_cnt_q, taken_cnt_d;

  logic [6:0]  opcode;
  logic [2:0]  funct3;
  logic        br_taken, br_illegal;
  logic        is_jal, is_jalr, is_br;
  logic        want_redirect, kill;
  logic [31:0] target;

  assign opcode = inst_q[6:0];
  assign funct3 = inst_q[14:12];

  branch_cmp u_cmp (
    .rs1_i     (rs1_x),
    .rs2_i     (rs2_x),
    .funct3_i  (funct3),
    .taken_o   (br_taken),
    .illegal_o (br_illegal)
  );

  // Decode the X instruction, pick the target and form redirect/link/illegal
  always_comb begin
    is_jal        = (opcode == OP_JAL);
    is_jalr       = (opcode == OP_JALR) && (funct3 == 3'b000);
    is_br         = (opcode == OP_BRANCH);
    target        = 32'h0;
    if (is_jal) begin
      target = pc_q + imm_j(inst_q);
    end else if (is_jalr) begin
      target = (rs1_x + imm_i(inst_q)) & 32'hFFFF_FFFE;
    end else if (is_br) begin
      target = pc_q + imm_b(inst_q);
    end
    want_redirect = inst_v_q & (is_jal | is_jalr | (is_br & br_taken));
    // Any would-be redirect, trapped or not, kills the instruction behind it
    kill          = want_redirect;
`ifdef BRANCH_MISALIGN_TRAP_EN
    trap_v_x      = want_redirect & target[1];
    trap_tval_x   = trap_v_x ? target : 32'h0;
    pc_v_x        = want_redirect & ~target[1];
    link_v_x      = inst_v_q & (is_jal | is_jalr) & ~trap_v_x;
`else
    pc_v_x        = want_redirect;
    link_v_x      = inst_v_q & (is_jal | is_jalr);
`endif
    pc_x          = pc_v_x ? target : 32'h0;
    // Link is only meaningful for a live instruction; keep it quiet otherwise
    link_x        = inst_v_q ? (pc_q + 32'd4) : 32'h0;
    illegal_x     = inst_v_q & is_br & br_illegal;
    inst_v_x      = inst_v_q;
    taken_cnt     = taken_cnt_q;
  end

  // Next-state for the I->X pipeline register and the saturating redirect counter
  always_comb begin
    inst_v_d    = inst_v_i & ~kill;
    pc_d        = pc_i;
    inst_d      = inst_i;
    taken_cnt_d = taken_cnt_q;
    if (pc_v_x && (taken_cnt_q != {CNT_W{1'b1}})) begin
      taken_cnt_d = taken_cnt_q + CNT_W'(1);
    end
  end

  // X-stage state with asynchronous reset to a valid-less NOP at RESET_PC
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      inst_v_q    <= 1'b0;
      pc_q        <= RESET_PC;
      inst_q      <= NOP_INST;
      taken_cnt_q <= '0;
    end else begin
      inst_v_q    <= inst_v_d;
      pc_q        <= pc_d;
      inst_q      <= inst_d;
      taken_cnt_q <= taken_cnt_d;
    end
  end

endmodule

// File: tb/tb_branch_resolve.sv
// tb/tb_branch_resolve.sv - scoreboard bench for branch_resolve with directed steps
module tb_branch_resolve;

  localparam int TB_CNT_W = 3;
  localparam logic [31:0] CNT_MAX = 32'd7;

  logic                clk = 1'b0;
  logic                reset_n;
  logic                inst_v_i;
  logic [31:0]         pc_i, inst_i, rs1_x, rs2_x;
  logic                inst_v_x, pc_v_x, link_v_x, illegal_x;
  logic [31:0]         pc_x, link_x;
  logic [TB_CNT_W-1:0] taken_cnt;
`ifdef BRANCH_MISALIGN_TRAP_EN
  logic                trap_v_x;
  logic [31:0]         trap_tval_x;
  localparam logic     TRAP_BUILD = 1'b1;
`else
  localparam logic     TRAP_BUILD = 1'b0;
`endif

  always #5 clk = ~clk;

  branch_resolve #(.CNT_W(TB_CNT_W), .RESET_PC(32'h0)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .inst_v_i    (inst_v_i),
    .pc_i        (pc_i),
    .inst_i      (inst_i),
    .rs1_x       (rs1_x),
    .rs2_x       (rs2_x),
    .inst_v_x    (inst_v_x),
    .pc_v_x      (pc_v_x),
    .pc_x        (pc_x),
    .link_v_x    (link_v_x),
    .link_x      (link_x),
    .illegal_x   (illegal_x),
`ifdef BRANCH_MISALIGN_TRAP_EN
    .trap_v_x    (trap_v_x),
    .trap_tval_x (trap_tval_x),
`endif
    .taken_cnt   (taken_cnt)
  );

  typedef struct {
    logic        iv;
    logic        pcv;
    logic [31:0] pc;
    logic        lv;
    logic [31:0] lk;
    logic        ill;
    logic        trap;
    logic [31:0] tval;
    logic [31:0] cnt;
  } exp_t;

  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  logic        prev_kill = 1'b0;
  logic [31:0] exp_cnt = 32'd0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] enc_b(input logic [2:0] f3, input logic [12:0] imm);
    return {imm[12], imm[10:5], 5'd2, 5'd1, f3, imm[4:1], imm[11], 7'b1100011};
  endfunction

  function automatic logic [31:0] enc_j(input logic [20:0] imm);
    return {imm[20], imm[10:1], imm[11], imm[19:12], 5'd1, 7'b1101111};
  endfunction

  function automatic logic [31:0] enc_jalr(input logic [2:0] f3, input logic [11:0] imm);
    return {imm, 5'd2, f3, 5'd1, 7'b1100111};
  endfunction

  // Drive one I-stage slot, push its expectation, then check it in X
  task automatic issue(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                       input logic [31:0] r1, input logic [31:0] r2,
                       input logic pcv, input logic [31:0] tgt,
                       input logic lv, input logic ill, input logic trap);
    exp_t e;
    @(negedge clk);
    inst_v_i = v;
    pc_i     = pc;
    inst_i   = inst;
    e.iv   = v & ~prev_kill;
    e.pcv  = e.iv & pcv;
    e.pc   = e.pcv ? tgt : 32'h0;
    e.lv   = e.iv & lv;
    e.lk   = pc + 32'd4;
    e.ill  = e.iv & ill;
    e.trap = e.iv & trap;
    e.tval = e.trap ? tgt : 32'h0;
    e.cnt  = exp_cnt;
    prev_kill = e.pcv | e.trap;
    if (e.pcv && exp_cnt != CNT_MAX) exp_cnt = exp_cnt + 32'd1;
    sb.push_back(e);
    @(posedge clk);
    #1;
    rs1_x    = r1;
    rs2_x    = r2;
    inst_v_i = 1'b0;
    #1;
    e = sb.pop_front();
    chk("inst_v_x", {31'd0, inst_v_x}, {31'd0, e.iv});
    chk("pc_v_x", {31'd0, pc_v_x}, {31'd0, e.pcv});
    chk("pc_x", pc_x, e.pc);
    chk("link_v_x", {31'd0, link_v_x}, {31'd0, e.lv});
    if (e.iv) chk("link_x", link_x, e.lk);
    chk("illegal_x", {31'd0, illegal_x}, {31'd0, e.ill});
    chk("taken_cnt", {{(32-TB_CNT_W){1'b0}}, taken_cnt}, e.cnt);
`ifdef BRANCH_MISALIGN_TRAP_EN
    chk("trap_v_x", {31'd0, trap_v_x}, {31'd0, e.trap});
    chk("trap_tval_x", trap_tval_x, e.tval);
`endif
  endtask

  task automatic bubble();
    issue(1'b0, 32'h0, 32'h0000_0013, 32'h0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    reset_n  = 1'b0;
    inst_v_i = 1'b1;
    pc_i     = 32'h0000_0800;
    inst_i   = enc_j(21'h40);
    rs1_x    = 32'h0;
    rs2_x    = 32'h0;
    repeat (3) @(posedge clk);
    #2;
    // Held in reset even with a live JAL presented upstream
    chk("rst inst_v_x", {31'd0, inst_v_x}, 32'd0);
    chk("rst pc_v_x", {31'd0, pc_v_x}, 32'd0);
    chk("rst pc_x", pc_x, 32'd0);
    chk("rst link_v_x", {31'd0, link_v_x}, 32'd0);
    chk("rst illegal_x", {31'd0, illegal_x}, 32'd0);
    chk("rst taken_cnt", {{(32-TB_CNT_W){1'b0}}, taken_cnt}, 32'd0);
    @(negedge clk);
    inst_v_i = 1'b0;
    reset_n  = 1'b1;

    // BEQ taken, then the following valid slot is killed
    issue(1'b1, 32'h100, enc_b(3'b000, 13'h020), 32'd5, 32'd5, 1'b1, 32'h120, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 32'h104, 32'h0000_0013, 32'd0, 32'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    // BLT signed -1 < 1 taken; BLTU 0xFFFFFFFF < 1 not taken and no kill
    issue(1'b1, 32'h300, enc_b(3'b100, 13'h040), 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h340, 1'b0, 1'b0, 1'b0);
    bubble();
    issue(1'b1, 32'h400, enc_b(3'b110, 13'h040), 32'hFFFF_FFFF, 32'd1, 1'b0, 32'h440, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 32'h404, 32'h0000_0013, 32'd0, 32'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    // BGEU 0xFFFFFFFF >= 1 taken
    issue(1'b1, 32'h408, enc_b(3'b111, 13'h010), 32'hFFFF_FFFF, 32'd1, 1'b1, 32'h418, 1'b0, 1'b0, 1'b0);
    bubble();
    // JALR with bit1 set in the target
    issue(1'b1, 32'h200, enc_jalr(3'b000, 12'h004), 32'h1003, 32'd0,
          ~TRAP_BUILD, 32'h1006, ~TRAP_BUILD, 1'b0, TRAP_BUILD);
    bubble();
    // JALR opcode with non-zero funct3 is not a jump
    issue(1'b1, 32'h210, enc_jalr(3'b001, 12'h004), 32'h1000, 32'd0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    // JAL wrapping past 2^32; link of the wrap-adjacent PC
    issue(1'b1, 32'hFFFF_FFF0, enc_j(21'h20), 32'd0, 32'd0, 1'b1, 32'h10, 1'b1, 1'b0, 1'b0);
    bubble();
    // Link wraps from 0xFFFFFFFC to 0
    issue(1'b1, 32'hFFFF_FFFC, enc_j(21'h8), 32'd0, 32'd0, 1'b1, 32'h4, 1'b1, 1'b0, 1'b0);
    bubble();
    // Reserved funct3 codes flag illegal and never redirect
    issue(1'b1, 32'h700, enc_b(3'b010, 13'h020), 32'd3, 32'd3, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    issue(1'b1, 32'h704, enc_b(3'b011, 13'h020), 32'd3, 32'd4, 1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
    // Back-to-back taken branches: BNE backward, BGE in the shadow is killed
    issue(1'b1, 32'h500, enc_b(3'b001, 13'h1FF8), 32'd1, 32'd2, 1'b1, 32'h4F8, 1'b0, 1'b0, 1'b0);
    issue(1'b1, 32'h504, enc_b(3'b101, 13'h010), 32'd5, 32'd5, 1'b1, 32'h514, 1'b0, 1'b0, 1'b0);
    // Drive the counter into saturation
    for (int k = 0; k < 4; k++) begin
      issue(1'b1, 32'h900 + 32'(k * 16), enc_j(21'h100), 32'd0, 32'd0,
            1'b1, 32'hA00 + 32'(k * 16), 1'b1, 1'b0, 1'b0);
      bubble();
    end

    // Asynchronous reset with a taken JAL sitting in X
    issue(1'b1, 32'h600, enc_j(21'h100), 32'd0, 32'd0, 1'b1, 32'h700, 1'b1, 1'b0, 1'b0);
    #1;
    reset_n = 1'b0;
    #1;
    chk("async pc_v_x", {31'd0, pc_v_x}, 32'd0);
    chk("async inst_v_x", {31'd0, inst_v_x}, 32'd0);
    chk("async taken_cnt", {{(32-TB_CNT_W){1'b0}}, taken_cnt}, 32'd0);
    @(negedge clk);
    reset_n   = 1'b1;
    prev_kill = 1'b0;
    exp_cnt   = 32'd0;
    // First instruction after release shows up in X one cycle later
    issue(1'b1, 32'h100, enc_b(3'b000, 13'h020), 32'd9, 32'd9, 1'b1, 32'h120, 1'b0, 1'b0, 1'b0);
    bubble();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
